// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcode constants, immediate formats,
// register index width and an opcode-to-immediate-format helper.
package riscv_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  // Immediate format implied by the major opcode.
  function automatic imm_type_e imm_type_of(input logic [6:0] opc);
    imm_type_e t;
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: t = IMM_I;
      OPC_STORE:                      t = IMM_S;
      OPC_BRANCH:                     t = IMM_B;
      OPC_LUI, OPC_AUIPC:             t = IMM_U;
      OPC_JAL:                        t = IMM_J;
      default:                        t = IMM_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: decodes the immediate of a 32-bit RISC-V instruction
// and sign-extends it to WIDTH. Purely combinational; shared with the branch
// unit.
//   instr  : raw instruction word
//   imm_c  : sign-extended immediate (0 for formats without an immediate)
module imm_gen
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [31:0]      instr,
  output logic [WIDTH-1:0] imm_c
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_type_of(instr[6:0]))
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm_c = WIDTH'($signed(imm32));
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage in front of the ALU. Generates the immediate, resolves
// operand forwarding, selects op1/op2, normalises funct3/funct7 and registers
// the result behind a valid/ready handshake with stall and flush.
// Optional feature macro: ALU_ISSUE_FWD_EN (EX/MEM operand forwarding).
// Without it the forwarding ports are ignored and the hazard unit must stall.
//   in_*            : decoded instruction, PC and regfile read data
//   ex_fwd_*/mem_*  : forwarding sources (EX has priority)
//   flush           : kills held and incoming instruction
//   out_* / op1.. : registered ALU controls and operands
module alu_issue_stage
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [WIDTH-1:0]      in_pc,
  input  logic [WIDTH-1:0]      in_rs1_data,
  input  logic [WIDTH-1:0]      in_rs2_data,
  input  logic                  flush,
  input  logic                  ex_fwd_valid,
  input  logic [REG_ADDR_W-1:0] ex_fwd_rd,
  input  logic [WIDTH-1:0]      ex_fwd_data,
  input  logic                  mem_fwd_valid,
  input  logic [REG_ADDR_W-1:0] mem_fwd_rd,
  input  logic [WIDTH-1:0]      mem_fwd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      op1,
  output logic [WIDTH-1:0]      op2,
  output logic [6:0]            opcode,
  output logic [2:0]            funct3,
  output logic [6:0]            funct7,
  output logic [2:0]            raw_funct3,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [WIDTH-1:0]      store_data
);

  logic [6:0]            in_opc;
  logic [2:0]            in_f3;
  logic [6:0]            in_f7;
  logic [REG_ADDR_W-1:0] in_rs1, in_rs2, in_rd;
  logic [WIDTH-1:0]      imm;
  logic [WIDTH-1:0]      rs1f, rs2f;

  assign in_opc = in_instr[6:0];
  assign in_rd  = in_instr[7 +: REG_ADDR_W];
  assign in_f3  = in_instr[14:12];
  assign in_rs1 = in_instr[15 +: REG_ADDR_W];
  assign in_rs2 = in_instr[20 +: REG_ADDR_W];
  assign in_f7  = in_instr[31:25];

  imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
    .instr (in_instr),
    .imm_c (imm)
  );

  // Operand source resolution; x0 never takes a forwarded value.
`ifdef ALU_ISSUE_FWD_EN
  always_comb begin
    rs1f = in_rs1_data;
    if (in_rs1 != '0) begin
      if (ex_fwd_valid && ex_fwd_rd == in_rs1)        rs1f = ex_fwd_data;
      else if (mem_fwd_valid && mem_fwd_rd == in_rs1) rs1f = mem_fwd_data;
    end
    rs2f = in_rs2_data;
    if (in_rs2 != '0) begin
      if (ex_fwd_valid && ex_fwd_rd == in_rs2)        rs2f = ex_fwd_data;
      else if (mem_fwd_valid && mem_fwd_rd == in_rs2) rs2f = mem_fwd_data;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                        mem_fwd_valid, mem_fwd_rd, mem_fwd_data};
  assign rs1f = in_rs1_data;
  assign rs2f = in_rs2_data;
`endif

  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      op1_q, op1_d, op2_q, op2_d, store_data_q, store_data_d;
  logic [6:0]            opcode_q, opcode_d, funct7_q, funct7_d;
  logic [2:0]            funct3_q, funct3_d, raw_funct3_q, raw_funct3_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  load;

  assign in_ready = !out_valid_q || out_ready;
  assign load     = in_valid && in_ready;

  // Next-state: flush wins, then load, then drain on consume; else hold.
  always_comb begin
    out_valid_d  = out_valid_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    opcode_d     = opcode_q;
    funct3_d     = funct3_q;
    funct7_d     = funct7_q;
    raw_funct3_d = raw_funct3_q;
    rd_d         = rd_q;
    store_data_d = store_data_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d  = 1'b1;
      opcode_d     = in_opc;
      raw_funct3_d = in_f3;
      rd_d         = in_rd;
      store_data_d = rs2f;
      op1_d        = '0;
      op2_d        = '0;
      funct3_d     = '0;
      funct7_d     = '0;
      case (in_opc)
        OPC_OP, OPC_BRANCH: begin
          op1_d    = rs1f;
          op2_d    = rs2f;
          funct3_d = in_f3;
          funct7_d = in_f7;
          if (in_opc == OPC_BRANCH) rd_d = '0;
        end
        OPC_OP_IMM: begin
          op1_d    = rs1f;
          op2_d    = imm;
          funct3_d = in_f3;
          // Only shift-right-immediate uses funct7 (SRAI vs SRLI).
          funct7_d = (in_f3 == 3'b101) ? in_f7 : 7'b0;
        end
        OPC_LOAD, OPC_STORE: begin
          op1_d = rs1f;
          op2_d = imm;
          if (in_opc == OPC_STORE) rd_d = '0;
        end
        OPC_LUI: op2_d = imm;
        OPC_AUIPC: begin
          op1_d = in_pc;
          op2_d = imm;
        end
        OPC_JAL, OPC_JALR: begin
          op1_d = in_pc;
          op2_d = WIDTH'(4);
        end
        default: ;
      endcase
    end else if (in_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      opcode_q     <= '0;
      funct3_q     <= '0;
      funct7_q     <= '0;
      raw_funct3_q <= '0;
      rd_q         <= '0;
      store_data_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      opcode_q     <= opcode_d;
      funct3_q     <= funct3_d;
      funct7_q     <= funct7_d;
      raw_funct3_q <= raw_funct3_d;
      rd_q         <= rd_d;
      store_data_q <= store_data_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign op1        = op1_q;
  assign op2        = op2_q;
  assign opcode     = opcode_q;
  assign funct3     = funct3_q;
  assign funct7     = funct7_q;
  assign raw_funct3 = raw_funct3_q;
  assign rd         = rd_q;
  assign store_data = store_data_q;

endmodule
